// File: rtl/boxcar_lpf_mc.sv
// Time-multiplexed multi-channel boxcar (moving-sum) low-pass filter with CLEAR drain/sweep control.
// Define BOXCAR_LPF_SAT_EN to clamp the shifted sum to the output range; otherwise it wraps.
module boxcar_lpf_mc #(
  parameter int SIGNAL_WIDTH = 10,
  parameter int PERIOD       = 18,
  parameter int CHANNELS     = 2,
  parameter int SHIFT        = 4,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [CH_W-1:0]                IN_CH,
  input  logic signed [SIGNAL_WIDTH-1:0] IN_DATA,
  input  logic                           CLEAR,
  output logic                           OUT_VALID,
  output logic [CH_W-1:0]                OUT_CH,
  output logic signed [SIGNAL_WIDTH-1:0] OUT_DATA
);

  localparam int SW    = SIGNAL_WIDTH + $clog2(PERIOD + 1);
  localparam int IDX_W = $clog2(PERIOD);
  localparam int CNT_W = $clog2(PERIOD + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PERIOD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PERIOD - 1);
  localparam logic [CH_W:0]    NUM_CH   = (CH_W + 1)'(CHANNELS);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

  state_t          state;
  logic            ready;
  logic [CH_W-1:0] sweep_ch;
  logic            accept;

  logic                           s1_valid;
  logic [CH_W-1:0]                s1_ch;
  logic signed [SIGNAL_WIDTH-1:0] s1_data;

  logic signed [SW-1:0]           sum_q [CHANNELS];
  logic [CNT_W-1:0]               cnt_q [CHANNELS];
  logic [IDX_W-1:0]               idx_q [CHANNELS];
  logic signed [SIGNAL_WIDTH-1:0] ring  [CHANNELS][PERIOD];

  logic signed [SW-1:0]           sum_cur;
  logic [CNT_W-1:0]               cnt_cur;
  logic [IDX_W-1:0]               idx_cur;
  logic signed [SIGNAL_WIDTH-1:0] oldest;
  logic                           full;
  logic signed [SW-1:0]           x_ext;
  logic signed [SW-1:0]           old_ext;
  logic signed [SW-1:0]           sum_new;
  logic signed [SIGNAL_WIDTH-1:0] out_fit;

  assign IN_READY = ready;
  assign accept   = IN_VALID && ready && !CLEAR && ({1'b0, IN_CH} < NUM_CH);

  // Control FSM: CLEAR waits for the pipeline to empty, then zeroes one channel per cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      ready    <= 1'b1;
      sweep_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CLEAR) begin
            state <= DRAIN;
            ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (!s1_valid && !OUT_VALID) begin
            state    <= SWEEP;
            sweep_ch <= '0;
          end
        end
        SWEEP: begin
          if (sweep_ch == LAST_CH) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            sweep_ch <= sweep_ch + CH_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ch   <= IN_CH;
        s1_data <= IN_DATA;
      end
    end
  end

  // Channel state is read and written back in the same stage, so a sample arriving
  // the very next cycle on the same channel already sees the updated sum/count/index.
  assign sum_cur = sum_q[s1_ch];
  assign cnt_cur = cnt_q[s1_ch];
  assign idx_cur = idx_q[s1_ch];
  assign oldest  = ring[s1_ch][idx_cur];
  assign full    = (cnt_cur == CNT_FULL);
  assign x_ext   = {{(SW - SIGNAL_WIDTH){s1_data[SIGNAL_WIDTH-1]}}, s1_data};
  assign old_ext = {{(SW - SIGNAL_WIDTH){oldest[SIGNAL_WIDTH-1]}}, oldest};
  assign sum_new = sum_cur + x_ext - (full ? old_ext : {SW{1'b0}});

`ifdef BOXCAR_LPF_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (SIGNAL_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (SIGNAL_WIDTH - 1)));

  logic signed [SW-1:0] shifted;

  assign shifted = sum_new >>> SHIFT;

  always_comb begin
    out_fit = shifted[SIGNAL_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      out_fit = SAT_MAX[SIGNAL_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      out_fit = SAT_MIN[SIGNAL_WIDTH-1:0];
    end
  end
`else
  assign out_fit = SIGNAL_WIDTH'(sum_new >>> SHIFT);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
        idx_q[c] <= '0;
      end
    end else if (state == SWEEP) begin
      sum_q[sweep_ch] <= '0;
      cnt_q[sweep_ch] <= '0;
      idx_q[sweep_ch] <= '0;
    end else if (s1_valid) begin
      sum_q[s1_ch] <= sum_new;
      if (!full) begin
        cnt_q[s1_ch] <= cnt_cur + CNT_W'(1);
      end
      idx_q[s1_ch] <= (idx_cur == IDX_LAST) ? '0 : idx_cur + IDX_W'(1);
    end
  end

  // Sample storage needs no reset: the fill count decides whether an entry is ever read.
  always_ff @(posedge CLK) begin
    if (s1_valid) begin
      ring[s1_ch][idx_cur] <= s1_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      OUT_CH    <= '0;
      OUT_DATA  <= '0;
    end else begin
      OUT_VALID <= s1_valid;
      if (s1_valid) begin
        OUT_CH   <= s1_ch;
        OUT_DATA <= out_fit;
      end
    end
  end

endmodule

// File: tb/tb_boxcar_lpf_mc.sv
// Directed bench for boxcar_lpf_mc: a 2-channel SHIFT=2 instance and a 3-channel SHIFT=0 instance.
// Expected saturation/wrap values follow BOXCAR_LPF_SAT_EN.
module tb_boxcar_lpf_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic              in_valid, in_ready, clear, out_valid;
  logic [0:0]        in_ch, out_ch;
  logic signed [9:0] in_data, out_data;

  logic              w_valid, w_ready, w_clear, w_out_valid;
  logic [1:0]        w_ch, w_out_ch;
  logic signed [9:0] w_data, w_out_data;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int mon_ch[$], mon_d[$], mon_cyc[$];
  int wmon_ch[$], wmon_d[$];
  int exp_ch[$], exp_d[$], exp_cyc[$];

  int t1_d[6]  = '{25, 50, 75, 100, 100, 100};
  int t2_d[8]  = '{25, -10, 50, -20, 75, -30, 100, -40};
  int t3_ch[11] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int t3_in[11] = '{8, -3, -8, -3, 40, 4, 100, 0, 0, 0, 0};
  int t3_d[11]  = '{2, -1, 0, -2, 10, 11, 34, 36, 26, 25, 0};
  int t6_ch[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 0};
`ifdef BOXCAR_LPF_SAT_EN
  int t6_d[10]  = '{511, 511, 511, 511, -512, -512, -512, -512, 7, 511};
`else
  int t6_d[10]  = '{511, -2, 509, -4, -512, 0, -512, 0, 7, -4};
`endif

  boxcar_lpf_mc #(
    .SIGNAL_WIDTH(10), .PERIOD(4), .CHANNELS(2), .SHIFT(2)
  ) dut (
    .CLK(clk), .RESET(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_CH(in_ch), .IN_DATA(in_data),
    .CLEAR(clear),
    .OUT_VALID(out_valid), .OUT_CH(out_ch), .OUT_DATA(out_data)
  );

  boxcar_lpf_mc #(
    .SIGNAL_WIDTH(10), .PERIOD(4), .CHANNELS(3), .SHIFT(0)
  ) dut_w (
    .CLK(clk), .RESET(rst),
    .IN_VALID(w_valid), .IN_READY(w_ready), .IN_CH(w_ch), .IN_DATA(w_data),
    .CLEAR(w_clear),
    .OUT_VALID(w_out_valid), .OUT_CH(w_out_ch), .OUT_DATA(w_out_data)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors record every result with the cycle it was visible in.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      mon_ch.push_back(int'(out_ch));
      mon_d.push_back(int'(out_data));
      mon_cyc.push_back(cyc);
    end
    if (w_out_valid === 1'b1) begin
      wmon_ch.push_back(int'(w_out_ch));
      wmon_d.push_back(int'(w_out_data));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, required finish before 100000ns");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input int ch, input int d, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_ch    = 1'(ch);
    in_data  = 10'(d);
    clear    = clr;
  endtask

  task automatic applyWide(input logic v, input int ch, input int d);
    @(negedge clk);
    w_valid = v;
    w_ch    = 2'(ch);
    w_data  = 10'(d);
  endtask

  task automatic idleAll(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; clear = 1'b0; w_valid = 1'b0; w_clear = 1'b0;
    end
  endtask

  task automatic clearQueues();
    mon_ch.delete(); mon_d.delete(); mon_cyc.delete();
    wmon_ch.delete(); wmon_d.delete();
    exp_ch.delete(); exp_d.delete(); exp_cyc.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; clear = 1'b0; w_valid = 1'b0; w_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearQueues();
  endtask

  task automatic expectOut(input int ch, input int d, input int c);
    exp_ch.push_back(ch);
    exp_d.push_back(d);
    exp_cyc.push_back(c);
  endtask

  task automatic checkStream(input string tag, input bit wide);
    int n;
    n = wide ? wmon_d.size() : mon_d.size();
    checkOutput($sformatf("%s count", tag), n, exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < n) begin
        if (wide) begin
          checkOutput($sformatf("%s data[%0d]", tag, i), wmon_d[i], exp_d[i]);
          checkOutput($sformatf("%s ch[%0d]", tag, i), wmon_ch[i], exp_ch[i]);
        end else begin
          checkOutput($sformatf("%s data[%0d]", tag, i), mon_d[i], exp_d[i]);
          checkOutput($sformatf("%s ch[%0d]", tag, i), mon_ch[i], exp_ch[i]);
          if (exp_cyc[i] >= 0) begin
            checkOutput($sformatf("%s cycle[%0d]", tag, i), mon_cyc[i], exp_cyc[i]);
          end
        end
      end
    end
  endtask

  initial begin
    int start;
    int low;
    bit seen;

    rst = 1'b1;
    in_valid = 1'b0; in_ch = '0; in_data = '0; clear = 1'b0;
    w_valid = 1'b0; w_ch = '0; w_data = '0; w_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_ch", int'(out_ch), 0);
    checkOutput("reset out_data", int'(out_data), 0);
    checkOutput("reset wide in_ready", int'(w_ready), 1);
    checkOutput("reset wide out_valid", int'(w_out_valid), 0);

    // Constant input on channel 0, one sample per cycle.
    clearQueues();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 0, 100, 1'b0);
      if (i == 0) start = cyc;
      expectOut(0, t1_d[i], start + 2 + i);
    end
    idleAll(4);
    checkStream("steady", 1'b0);

    // Interleaved channels must not disturb each other.
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, i % 2, (i % 2 == 0) ? 100 : -40, 1'b0);
      if (i == 0) start = cyc;
      expectOut(i % 2, t2_d[i], start + 2 + i);
    end
    idleAll(4);
    checkStream("interleave", 1'b0);

    // Mixed-sign data, oldest-sample subtraction and index wrap.
    resetDut();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, t3_ch[i], t3_in[i], 1'b0);
      if (i == 0) start = cyc;
      expectOut(t3_ch[i], t3_d[i], start + 2 + i);
    end
    idleAll(4);
    checkStream("mixed", 1'b0);

    // CLEAR with a simultaneous sample; valid and CLEAR held while not ready.
    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 0, 100, 1'b0);
      if (i == 0) start = cyc;
      expectOut(0, t1_d[i], start + 2 + i);
    end
    applyStimulus(1'b1, 0, 100, 1'b1);
    low = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b0; clear = 1'b0;
        seen = 1'b1;
        break;
      end
      low++;
      in_valid = 1'b1; in_ch = '0; in_data = 10'sd100; clear = 1'b1;
    end
    checkOutput("clear ready returns", int'(seen), 1);
    checkOutput("clear ready low cycles", low, 4);
    applyStimulus(1'b1, 0, 100, 1'b0);
    expectOut(0, 25, cyc + 2);
    idleAll(4);
    checkStream("clear", 1'b0);

    // Reset with samples in flight discards them.
    resetDut();
    applyStimulus(1'b1, 0, 100, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_ch = '0; in_data = 10'sd100;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("midreset out_valid", int'(out_valid), 0);
    checkOutput("midreset out_data", int'(out_data), 0);
    checkOutput("midreset out_ch", int'(out_ch), 0);
    @(negedge clk);
    checkOutput("midreset in_ready", int'(in_ready), 1);
    idleAll(3);
    checkOutput("midreset no output", mon_d.size(), 0);
    applyStimulus(1'b1, 0, 100, 1'b0);
    expectOut(0, 25, cyc + 2);
    idleAll(4);
    checkStream("midreset", 1'b0);

    // Full-scale sums, negative extremes, third channel and out-of-range channel.
    resetDut();
    for (int i = 0; i < 4; i++) applyWide(1'b1, 0, 511);
    for (int i = 0; i < 4; i++) applyWide(1'b1, 1, -512);
    applyWide(1'b1, 2, 7);
    applyWide(1'b1, 3, 100);
    idleAll(4);
    checkOutput("wide count before refill", wmon_d.size(), 9);
    applyWide(1'b1, 0, 511);
    idleAll(4);
    for (int i = 0; i < 10; i++) expectOut(t6_ch[i], t6_d[i], -1);
    checkStream("wide", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
